// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem request master.
package dmem_pkg;

   // Tag storage width inside the pending FIFO; the top-level TAG_W must not exceed it.
   localparam int unsigned TAG_MAX_W = 16;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RMW_RD   = 2'd1,
      RMW_WAIT = 2'd2,
      RMW_WR   = 2'd3
   } rmw_state_e;

   // Size is kept as raw bits so the reserved encoding (3) still behaves as a word.
   typedef struct packed {
      logic [TAG_MAX_W-1:0] tag;
      logic [1:0]           size;
      logic                 is_unsigned;
      logic [1:0]           off;
      logic                 kill;
   } pend_entry_t;

   // Half on an odd byte, or word/reserved not on a word boundary.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return off[0];
         default: return off != 2'b00;
      endcase
   endfunction

   // Pick the addressed byte/half out of a bus word and extend it.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic uns, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: return uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   // Overlay right-aligned store data onto the old word at the byte offset.
   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
      logic [31:0] res;
      res = old;
      case (size)
         SZ_BYTE: res[{off, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: begin
            if (off[1]) res[31:16] = wdata[15:0];
            else        res[15:0]  = wdata[15:0];
         end
         default: res = wdata;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_req_master_pend_fifo.sv
// In-order FIFO of loads awaiting their bus response.
module pend_fifo
   import dmem_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  pend_entry_t      push_entry,
   input  logic             pop,
   input  logic             kill_all,
   output pend_entry_t      head,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   pend_entry_t      slots [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   assign head = slots[rd_ptr];

   // Pointer wrap that also works for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Storage, pointers and occupancy; kill_all marks everything present, a same-cycle push keeps its own kill.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) slots[i] <= '0;
      end else begin
         if (kill_all) begin
            for (int unsigned i = 0; i < DEPTH; i++) slots[i].kill <= 1'b1;
         end
         if (push) begin
            slots[wr_ptr] <= push_entry;
            wr_ptr        <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/dmem_req_master.sv
// LSU-to-dmem initiator: pipelined loads, sub-word extraction, RMW for sub-word stores.
module dmem_req_master
   import dmem_pkg::*;
#(
   parameter int unsigned TAG_W           = 6,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic             op_we,
   input  logic [1:0]       op_size,
   input  logic             op_unsigned,
   input  logic [31:0]      op_addr,
   input  logic [31:0]      op_wdata,
   input  logic [TAG_W-1:0] op_tag,
   input  logic             flush,
   output logic             dmem_req_valid,
   input  logic             dmem_req_ready,
   output logic             dmem_req_we,
   output logic [31:0]      dmem_req_addr,
   output logic [31:0]      dmem_req_data,
   input  logic             dmem_resp_valid,
   input  logic [31:0]      dmem_resp_data,
   output logic             done_valid,
   output logic [TAG_W-1:0] done_tag,
   output logic [31:0]      done_data,
   output logic             done_misaligned,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

   rmw_state_e       state;
   logic [CNT_W-1:0] outstanding;
   pend_entry_t      head;
   pend_entry_t      push_entry;

   logic [29:0]      rmw_word_addr;
   logic [TAG_W-1:0] rmw_tag;
   logic [1:0]       rmw_size;
   logic [1:0]       rmw_off;
   logic [31:0]      rmw_wdata;
   logic [31:0]      rmw_merged;

   logic misaligned, is_word, drained, op_fire;
   logic acc_mis, acc_load, acc_wst, acc_sst;
   logic load_resp, wr_fire;

   assign misaligned = is_misaligned(op_size, op_addr[1:0]);
   assign is_word    = op_size[1];
   assign drained    = (outstanding == '0);
   assign busy       = (state != IDLE) || !drained;

   // Acceptance: loads need a free slot and the bus; stores and misaligned ops need an empty pipe.
   always_comb begin
      op_ready = 1'b0;
      if (!reset && state == IDLE) begin
         if (misaligned)   op_ready = drained;
         else if (!op_we)  op_ready = (outstanding < CNT_W'(MAX_OUTSTANDING)) && dmem_req_ready;
         else if (is_word) op_ready = drained && dmem_req_ready;
         else              op_ready = drained;
      end
   end

   assign op_fire   = op_valid && op_ready;
   assign acc_mis   = op_fire && misaligned;
   assign acc_load  = op_fire && !misaligned && !op_we;
   assign acc_wst   = op_fire && !misaligned && op_we && is_word;
   assign acc_sst   = op_fire && !misaligned && op_we && !is_word;
   assign load_resp = dmem_resp_valid && (state != RMW_WAIT) && !drained;
   assign wr_fire   = (state == RMW_WR) && dmem_req_ready;

   // Bus request: straight from the op port in IDLE, from latched RMW state otherwise.
   always_comb begin
      dmem_req_valid = 1'b0;
      dmem_req_we    = 1'b0;
      dmem_req_addr  = '0;
      dmem_req_data  = '0;
      case (state)
         IDLE: begin
            if (acc_load || acc_wst) begin
               dmem_req_valid = 1'b1;
               dmem_req_we    = op_we;
               dmem_req_addr  = {op_addr[31:2], 2'b00};
               dmem_req_data  = op_we ? op_wdata : '0;
            end
         end
         RMW_RD: begin
            dmem_req_valid = 1'b1;
            dmem_req_addr  = {rmw_word_addr, 2'b00};
         end
         RMW_WR: begin
            dmem_req_valid = 1'b1;
            dmem_req_we    = 1'b1;
            dmem_req_addr  = {rmw_word_addr, 2'b00};
            dmem_req_data  = rmw_merged;
         end
         default: ;
      endcase
   end

   // Entry recorded for each accepted load; a same-cycle flush kills it on entry.
   always_comb begin
      push_entry             = '0;
      push_entry.tag         = TAG_MAX_W'(op_tag);
      push_entry.size        = op_size;
      push_entry.is_unsigned = op_unsigned;
      push_entry.off         = op_addr[1:0];
      push_entry.kill        = flush;
   end

   pend_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pend_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (acc_load),
      .push_entry (push_entry),
      .pop        (load_resp),
      .kill_all   (flush),
      .head       (head),
      .count      (outstanding)
   );

   // Sub-word store read-modify-write sequencer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rmw_word_addr <= '0;
         rmw_tag       <= '0;
         rmw_size      <= '0;
         rmw_off       <= '0;
         rmw_wdata     <= '0;
         rmw_merged    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (acc_sst) begin
                  state         <= RMW_RD;
                  rmw_word_addr <= op_addr[31:2];
                  rmw_tag       <= op_tag;
                  rmw_size      <= op_size;
                  rmw_off       <= op_addr[1:0];
                  rmw_wdata     <= op_wdata;
               end
            end
            RMW_RD:   if (dmem_req_ready) state <= RMW_WAIT;
            RMW_WAIT: begin
               if (dmem_resp_valid) begin
                  rmw_merged <= store_merge(dmem_resp_data, rmw_wdata, rmw_size, rmw_off);
                  state      <= RMW_WR;
               end
            end
            RMW_WR:   if (dmem_req_ready) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   // Completion pulse; the sources are mutually exclusive by construction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_valid      <= 1'b0;
         done_tag        <= '0;
         done_data       <= '0;
         done_misaligned <= 1'b0;
      end else begin
         done_valid <= 1'b0;
         if (load_resp) begin
            if (!head.kill) begin
               done_valid      <= 1'b1;
               done_tag        <= TAG_W'(head.tag);
               done_data       <= load_extract(dmem_resp_data, head.size, head.is_unsigned, head.off);
               done_misaligned <= 1'b0;
            end
         end else if (acc_mis || acc_wst) begin
            done_valid      <= 1'b1;
            done_tag        <= op_tag;
            done_data       <= '0;
            done_misaligned <= acc_mis;
         end else if (wr_fire) begin
            done_valid      <= 1'b1;
            done_tag        <= rmw_tag;
            done_data       <= '0;
            done_misaligned <= 1'b0;
         end
      end
   end

   // A response with nothing outstanding is a responder bug; it is dropped.
   resp_protocol_a : assert property (@(posedge clk) disable iff (reset)
      !(dmem_resp_valid && drained && state != RMW_WAIT));

endmodule

// File: tb/tb_dmem_req_master.sv
// Scoreboard bench for dmem_req_master with a simple in-order memory responder.
module tb_dmem_req_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid, op_ready, op_we, op_unsigned, flush;
   logic [1:0]  op_size;
   logic [31:0] op_addr, op_wdata;
   logic [5:0]  op_tag;
   logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
   logic [31:0] dmem_req_addr, dmem_req_data;
   logic        dmem_resp_valid;
   logic [31:0] dmem_resp_data;
   logic        done_valid, done_misaligned, busy;
   logic [5:0]  done_tag;
   logic [31:0] done_data;

   always #5 clk = ~clk;

   dmem_req_master #(.TAG_W(6), .MAX_OUTSTANDING(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .op_valid        (op_valid),
      .op_ready        (op_ready),
      .op_we           (op_we),
      .op_size         (op_size),
      .op_unsigned     (op_unsigned),
      .op_addr         (op_addr),
      .op_wdata        (op_wdata),
      .op_tag          (op_tag),
      .flush           (flush),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_req_we     (dmem_req_we),
      .dmem_req_addr   (dmem_req_addr),
      .dmem_req_data   (dmem_req_data),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_resp_data  (dmem_resp_data),
      .done_valid      (done_valid),
      .done_tag        (done_tag),
      .done_data       (done_data),
      .done_misaligned (done_misaligned),
      .busy            (busy)
   );

   typedef struct { logic [5:0] tag; logic [31:0] data; logic mis; } done_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } bus_t;

   done_t       exp_done [$];
   bus_t        exp_bus  [$];
   logic [31:0] rq       [$];
   logic [31:0] mem      [logic [31:0]];
   logic        hold;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic exp_rd(input logic [31:0] a);
      bus_t b; b.we = 1'b0; b.addr = a; b.data = '0; exp_bus.push_back(b);
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      bus_t b; b.we = 1'b1; b.addr = a; b.data = d; exp_bus.push_back(b);
   endtask

   task automatic exp_dn(input logic [5:0] t, input logic [31:0] d, input logic m);
      done_t e; e.tag = t; e.data = d; e.mis = m; exp_done.push_back(e);
   endtask

   // Present one op from posedge+1 until it is taken; returns at posedge+1 after the accepting edge.
   task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [5:0] t);
      int w = 0;
      op_valid = 1'b1; op_we = we; op_size = sz; op_unsigned = uns;
      op_addr = a; op_wdata = wd; op_tag = t;
      @(negedge clk);
      while (!op_ready && w < 60) begin w++; @(negedge clk); end
      check($sformatf("accept_tag%0d", t), {31'h0, op_ready}, 32'h1);
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   // Responder capture: writes update memory, reads queue their data.
   always @(negedge clk) begin
      if (!reset && dmem_req_valid && dmem_req_ready) begin
         if (dmem_req_we) mem[dmem_req_addr] = dmem_req_data;
         else rq.push_back(mem.exists(dmem_req_addr) ? mem[dmem_req_addr] : 32'h0);
      end
   end

   // Responder: one response per cycle, at least one edge after the request.
   initial begin
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            rq.delete();
            dmem_resp_valid = 1'b0;
         end else if (!hold && rq.size() > 0) begin
            dmem_resp_valid = 1'b1;
            dmem_resp_data  = rq.pop_front();
         end else begin
            dmem_resp_valid = 1'b0;
         end
      end
   end

   // Monitor: compare bus requests and completions against the expectation queues.
   always @(negedge clk) begin
      if (!reset && dmem_req_valid && dmem_req_ready) begin
         if (exp_bus.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL bus_unexpected: we=%b addr=%h, expected no request", dmem_req_we, dmem_req_addr);
         end else begin
            bus_t b;
            b = exp_bus.pop_front();
            check("bus_we", {31'h0, dmem_req_we}, {31'h0, b.we});
            check("bus_addr", dmem_req_addr, b.addr);
            if (b.we) check("bus_wdata", dmem_req_data, b.data);
         end
      end
      if (!reset && done_valid) begin
         if (exp_done.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL done_unexpected: tag=%0d data=%h, expected no completion", done_tag, done_data);
         end else begin
            done_t e;
            e = exp_done.pop_front();
            check("done_tag", {26'h0, done_tag}, {26'h0, e.tag});
            check("done_data", done_data, e.data);
            check("done_mis", {31'h0, done_misaligned}, {31'h0, e.mis});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      mem[32'h100] = 32'hDEADBEEF;
      mem[32'h180] = 32'h80FF1234;
      mem[32'h200] = 32'h11223344;
      hold = 1'b0; flush = 1'b0; dmem_req_ready = 1'b1;
      op_valid = 1'b1; op_we = 1'b0; op_size = 2'd2; op_unsigned = 1'b0;
      op_addr = 32'h100; op_wdata = '0; op_tag = 6'd1;
      reset = 1'b1;

      // Reset state, with an op offered that must not reach the bus.
      repeat (2) @(posedge clk); #1;
      check("rst_done_valid", {31'h0, done_valid}, 32'h0);
      check("rst_done_tag", {26'h0, done_tag}, 32'h0);
      check("rst_done_data", done_data, 32'h0);
      check("rst_done_mis", {31'h0, done_misaligned}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_req_valid", {31'h0, dmem_req_valid}, 32'h0);
      check("rst_op_ready", {31'h0, op_ready}, 32'h0);
      op_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;

      // Loads with extraction.
      exp_rd(32'h100); exp_dn(6'd5,  32'hDEADBEEF, 1'b0); send(1'b0, 2'd2, 1'b0, 32'h100, 0, 6'd5);
      exp_rd(32'h180); exp_dn(6'd6,  32'hFFFFFF80, 1'b0); send(1'b0, 2'd0, 1'b0, 32'h183, 0, 6'd6);
      exp_rd(32'h180); exp_dn(6'd7,  32'h00000080, 1'b0); send(1'b0, 2'd0, 1'b1, 32'h183, 0, 6'd7);
      exp_rd(32'h180); exp_dn(6'd8,  32'hFFFF80FF, 1'b0); send(1'b0, 2'd1, 1'b0, 32'h182, 0, 6'd8);
      exp_rd(32'h180); exp_dn(6'd9,  32'h00001234, 1'b0); send(1'b0, 2'd1, 1'b1, 32'h180, 0, 6'd9);
      exp_rd(32'h180); exp_dn(6'd10, 32'h00000012, 1'b0); send(1'b0, 2'd0, 1'b0, 32'h181, 0, 6'd10);

      // Sub-word stores through read-modify-write, then a word store.
      exp_rd(32'h200); exp_wr(32'h200, 32'h1122AB44); exp_dn(6'd11, 0, 1'b0);
      send(1'b1, 2'd0, 1'b0, 32'h201, 32'h000000AB, 6'd11);
      exp_rd(32'h200); exp_wr(32'h200, 32'h5566AB44); exp_dn(6'd12, 0, 1'b0);
      send(1'b1, 2'd1, 1'b0, 32'h202, 32'hFFFF5566, 6'd12);
      exp_wr(32'h204, 32'hCAFEF00D); exp_dn(6'd13, 0, 1'b0);
      send(1'b1, 2'd2, 1'b0, 32'h204, 32'hCAFEF00D, 6'd13);
      @(negedge clk);
      check("sw_done_next_cycle", {31'h0, done_valid}, 32'h1);
      @(posedge clk); #1;
      exp_rd(32'h200); exp_dn(6'd14, 32'h5566AB44, 1'b0); send(1'b0, 2'd2, 1'b0, 32'h200, 0, 6'd14);

      // Misaligned ops: no bus traffic, flagged completion one cycle after accept.
      exp_dn(6'd15, 0, 1'b1); send(1'b0, 2'd1, 1'b0, 32'h101, 0, 6'd15);
      @(negedge clk);
      check("mis_done_next_cycle", {30'h0, done_valid, done_misaligned}, 32'h3);
      @(posedge clk); #1;
      exp_dn(6'd16, 0, 1'b1); send(1'b0, 2'd2, 1'b0, 32'h102, 0, 6'd16);
      exp_dn(6'd17, 0, 1'b1); send(1'b1, 2'd2, 1'b0, 32'h201, 32'h12345678, 6'd17);
      exp_dn(6'd18, 0, 1'b1); send(1'b1, 2'd1, 1'b0, 32'h203, 32'h00001111, 6'd18);
      exp_rd(32'h204); exp_dn(6'd19, 32'hCAFEF00D, 1'b0); send(1'b0, 2'd3, 1'b0, 32'h204, 0, 6'd19);

      // Three back-to-back loads: the third stalls until the first response.
      hold = 1'b1;
      exp_rd(32'h100); exp_dn(6'd20, 32'hDEADBEEF, 1'b0); send(1'b0, 2'd2, 1'b0, 32'h100, 0, 6'd20);
      exp_rd(32'h180); exp_dn(6'd21, 32'h80FF1234, 1'b0); send(1'b0, 2'd2, 1'b0, 32'h180, 0, 6'd21);
      exp_rd(32'h204); exp_dn(6'd22, 32'hCAFEF00D, 1'b0);
      fork
         send(1'b0, 2'd2, 1'b0, 32'h204, 0, 6'd22);
         begin
            @(negedge clk); check("stall_a", {31'h0, op_ready}, 32'h0);
            @(negedge clk); check("stall_b", {31'h0, op_ready}, 32'h0);
            hold = 1'b0;
         end
      join

      // Flush kills both in-flight loads, including one accepted in the flush cycle.
      @(negedge clk); hold = 1'b1;
      @(posedge clk); #1;
      exp_rd(32'h100); send(1'b0, 2'd2, 1'b0, 32'h100, 0, 6'd30);
      exp_rd(32'h180);
      fork
         send(1'b0, 2'd2, 1'b0, 32'h180, 0, 6'd31);
         begin flush = 1'b1; @(posedge clk); #1; flush = 1'b0; end
      join
      @(negedge clk); hold = 1'b0;
      @(posedge clk); #1;
      exp_rd(32'h204); exp_dn(6'd32, 32'hCAFEF00D, 1'b0); send(1'b0, 2'd2, 1'b0, 32'h204, 0, 6'd32);

      // Reset with a load in flight clears everything at once.
      @(negedge clk); hold = 1'b1;
      @(posedge clk); #1;
      exp_rd(32'h100); send(1'b0, 2'd2, 1'b0, 32'h100, 0, 6'd40);
      check("busy_inflight", {31'h0, busy}, 32'h1);
      @(negedge clk); reset = 1'b1; #1;
      check("midrst_busy", {31'h0, busy}, 32'h0);
      @(negedge clk); @(negedge clk); reset = 1'b0; hold = 1'b0;
      @(posedge clk); #1;
      exp_rd(32'h100); exp_dn(6'd41, 32'hDEADBEEF, 1'b0); send(1'b0, 2'd2, 1'b0, 32'h100, 0, 6'd41);

      // Drain and confirm every expectation was consumed.
      begin
         int w = 0;
         while ((exp_done.size() != 0 || exp_bus.size() != 0) && w < 100) begin
            w++; @(posedge clk);
         end
      end
      repeat (5) @(posedge clk);
      check("drain_done_queue", exp_done.size(), 32'h0);
      check("drain_bus_queue", exp_bus.size(), 32'h0);
      check("final_busy", {31'h0, busy}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_req_master.md
# dmem_req_master

Initiator side of the CPU data-memory request/response interface (`dmem_req_*` / `dmem_resp_*`). It accepts load/store ops from the LSU over a valid/ready port and issues word-granular requests on the dmem bus. It pipelines loads, extracts and sign-extends sub-word load data, and turns sub-word stores into a read-modify-write sequence, because the bus has no byte enables. It sits between the LSU/store-buffer drain and the memory responder, and returns one tagged completion per accepted op.

## Interface
- TAG_W, 6: width of op/completion tag.
- MAX_OUTSTANDING, 2: max loads in flight on dmem bus (power of 2, ≥1).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- op_valid / op_ready  in / out  1  op handshake; transfer when both high at posedge.
- op_we  in  1  1 = store, 0 = load.
- op_size  in  2  0 byte, 1 half, 2 word (3 reserved, treated as word).
- op_unsigned  in  1  zero-extend sub-word load.
- op_addr  in  32  byte address.
- op_wdata  in  32  store data, right-aligned.
- op_tag  in  TAG_W  returned on completion.
- flush  in  1  discard results of in-flight loads.
- dmem_req_valid / dmem_req_ready  out / in  1  bus handshake.
- dmem_req_we  out  1  write request.
- dmem_req_addr  out  32  word-aligned address (addr[1:0]=0).
- dmem_req_data  out  32  write data.
- dmem_resp_valid  in  1  read data valid; responses in request order, latency ≥1.
- dmem_resp_data  in  32  read word.
- done_valid  out  1  one-cycle completion pulse.
- done_tag  out  TAG_W  tag of completed op.
- done_data  out  32  extended load data (0 for stores).
- done_misaligned  out  1  op was misaligned and not performed.
- busy  out  1  state≠IDLE or outstanding≠0.

## Operation
- **Misaligned check:**
  - half with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - Accepted only when IDLE with outstanding=0.
  - No bus request is issued; completion is signalled with done_misaligned=1.
- **Loads:**
  - op_ready = IDLE ∧ outstanding<MAX_OUTSTANDING ∧ dmem_req_ready.
  - On acceptance, the request is driven combinationally the same cycle: req_valid=1, we=0, addr={op_addr[31:2],2'b00}.
  - Pushed to an in-order pending FIFO: tag, size, unsigned, addr[1:0], kill=0.
- **Load response:**
  - Pop FIFO head.
  - Select byte addr[1:0] or half addr[1]; sign- or zero-extend; word passes through.
  - If kill=0, pulse done next cycle.
- **Word store:**
  - Accepted only when IDLE ∧ outstanding=0 ∧ dmem_req_ready.
  - One write request in the acceptance cycle.
  - done_valid next cycle.
- **Sub-word store (FSM):**
  - IDLE→RMW_RD on acceptance; op fields are latched; op_ready=0 from then on.
  - RMW_RD: issue read of the word; on handshake go to RMW_WAIT.
  - RMW_WAIT: on resp_valid, merge the store byte/half into the word at addr[1:0] and go to RMW_WR.
  - RMW_WR: issue write of the merged word; on handshake go to IDLE and pulse done next cycle.
- **flush:**
  - Sets kill on every FIFO entry present that cycle; their responses are still consumed, but done is suppressed.
  - A load accepted in the same cycle as flush is also killed.
  - flush does not affect the RMW sequence or stores (stores are post-commit).
- **Exclusivity:** at most one done source per cycle. Stores and misaligned ops require outstanding=0, so a store completion never coincides with a load response.
- **Bus response rule:** dmem_resp_valid with FIFO empty and state≠RMW_WAIT is a protocol error. Ignore it; assert in simulation.

## Timing
- Reset values: done_valid=0, done_tag=0, done_data=0, done_misaligned=0, busy=0, FSM=IDLE, FIFO empty.
- dmem_req_* is combinational from the op port in IDLE and registered-state-driven in RMW_RD/RMW_WR. dmem_req_valid=0 during reset.
- Load completion: done at resp cycle+1. Against a 1-cycle-latency responder (resp_valid 2 edges after request), load accept→done = 3 cycles.
- Back-to-back loads are accepted every cycle while outstanding<MAX_OUTSTANDING. A push and a pop in the same cycle keep the count unchanged.
- Sub-word store with the same responder: accept, RD issue, resp, WR issue, done. RMW_RD is entered with req_valid the cycle after accept.
- Reset mid-operation: FIFO, FSM and counters are cleared immediately. Late bus responses after reset are ignored by the protocol-error rule.

## Structure
- Shared package `dmem_pkg`:
  - enum `mem_size_e` (BYTE/HALF/WORD).
  - typedef `pend_entry_t` (tag, size, unsigned, off, kill).
  - FSM enum `rmw_state_e`.
  - Functions `load_extract()` and `store_merge()`.
- One sub-module `pend_fifo` (depth MAX_OUTSTANDING, push/pop/kill_all, count output).

## Test plan
- LW 0x100 holding 0xDEADBEEF, tag 5 → one read at 0x100; done tag 5, data 0xDEADBEEF.
- LB 0x103 of word 0x80FF1234 → done_data 0xFFFFFF80. LBU → 0x00000080. LH 0x102 → 0xFFFF80FF.
- SB 0x201 data 0xAB onto 0x11223344 → read, then write 0x1122AB44 to 0x200; done, data 0.
- Three LWs back-to-back, MAX_OUTSTANDING=2 → third stalls (op_ready=0) until first resp. dones in order with correct tags.
- Two loads in flight, then flush → both responses consumed, no done. A next load completes normally.
- LH 0x101 → no bus request; done next cycle with done_misaligned=1, tag echoed.
